// File: rtl/out_channel_pkg.sv
// Shared types and defaults for the output channel arbiter.
// Provides the RUN/FLUSH state enum, default sizes and an index-width helper.
package out_channel_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam int DefWidth = 12;
    localparam int DefNReq  = 4;
    localparam int DefNOut  = 100;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/out_channel_rr_arbiter.sv
// One-hot requester selection for the output channel arbiter.
// Ports: req (requests), ptr (search start index), grant (one-hot result).
module out_channel_rr_arbiter
    import out_channel_pkg::*;
#(
    parameter  int NRequesters = DefNReq,
    localparam int IW          = idx_w(NRequesters)
) (
    input  logic [NRequesters-1:0] req,
    input  logic [IW-1:0]          ptr,
    output logic [NRequesters-1:0] grant
);

`ifdef OUT_CHANNEL_FIXED_PRIORITY_EN

    logic unused_ptr;
    assign unused_ptr = ^ptr;

    // Walk downward so the lowest asserted index is written last.
    always_comb begin
        grant = '0;
        for (int i = NRequesters - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
    end

`else

    // Walk offsets downward so the smallest offset from ptr wins.
    always_comb begin
        int          idx;
        logic [IW-1:0] sel;
        grant = '0;
        idx   = 0;
        sel   = '0;
        for (int k = NRequesters - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NRequesters) idx = idx - NRequesters;
            sel = IW'(idx);
            if (req[sel]) begin
                grant      = '0;
                grant[sel] = 1'b1;
            end
        end
    end

`endif

endmodule

// File: rtl/out_channel_arbiter.sv
// Arbitrates N requesters into a ring buffer drained by a valid/ready consumer,
// with a flush mode that blocks writes until the buffer is empty.
// Ports: clock, reset (async active-low), req/reqData/grant (writers),
// outValid/outData/outReady (consumer), flush/flushDone, full/empty/count.
// Build option: OUT_CHANNEL_FIXED_PRIORITY_EN selects lowest-index-wins
// arbitration instead of round-robin.
module out_channel_arbiter
    import out_channel_pkg::*;
#(
    parameter int MemoryElementWidth = DefWidth,
    parameter int NRequesters        = DefNReq,
    parameter int NOut               = DefNOut
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic [NRequesters-1:0]                    req,
    input  logic [NRequesters*MemoryElementWidth-1:0] reqData,
    output logic [NRequesters-1:0]                    grant,
    input  logic                                      flush,
    output logic                                      outValid,
    output logic [MemoryElementWidth-1:0]             outData,
    input  logic                                      outReady,
    output logic                                      full,
    output logic                                      empty,
    output logic [$clog2(NOut+1)-1:0]                 count,
    output logic                                      flushDone
);

    localparam int W  = MemoryElementWidth;
    localparam int CW = $clog2(NOut + 1);
    localparam int PW = idx_w(NOut);
    localparam int IW = idx_w(NRequesters);

    state_t               state;
    state_t               state_next;
    logic                 done_next;
    logic [PW-1:0]        wr_pos;
    logic [PW-1:0]        rd_pos;
    logic [CW-1:0]        cnt_next;
    logic [IW-1:0]        ptr;
    logic [NRequesters-1:0] arb_grant;
    logic [W-1:0]         wdata;
    logic                 can_grant;
    logic                 push;
    logic                 pop;
    logic [W-1:0]         mem [NOut];

    function automatic logic [PW-1:0] adv(input logic [PW-1:0] p);
        return (p == PW'(NOut - 1)) ? '0 : p + PW'(1);
    endfunction

    out_channel_rr_arbiter #(
        .NRequesters(NRequesters)
    ) u_arb (
        .req  (req),
        .ptr  (ptr),
        .grant(arb_grant)
    );

    // Reset gates grant directly so it is low while reset is held.
    assign can_grant = reset && (state == RUN) && !full;
    assign grant     = can_grant ? arb_grant : '0;
    assign push      = |grant;
    assign pop       = outValid && outReady;

    assign empty    = (count == '0);
    assign full     = (count == CW'(NOut));
    assign outValid = !empty;
    assign outData  = mem[rd_pos];

    always_comb begin
        wdata = '0;
        for (int i = 0; i < NRequesters; i++) begin
            if (grant[i]) wdata = wdata | reqData[i*W +: W];
        end
    end

    always_comb begin
        cnt_next = count;
        unique case ({push, pop})
            2'b10:   cnt_next = count + CW'(1);
            2'b01:   cnt_next = count - CW'(1);
            default: cnt_next = count;
        endcase
    end

    // No writes happen in FLUSH, so cnt_next only falls there.
    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        unique case (state)
            RUN: begin
                if (flush) state_next = FLUSH;
            end
            FLUSH: begin
                if (cnt_next == '0) begin
                    state_next = RUN;
                    done_next  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            flushDone <= 1'b0;
            wr_pos    <= '0;
            rd_pos    <= '0;
            count     <= '0;
        end else begin
            state     <= state_next;
            flushDone <= done_next;
            count     <= cnt_next;
            if (push) wr_pos <= adv(wr_pos);
            if (pop)  rd_pos <= adv(rd_pos);
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_pos] <= wdata;
    end

`ifdef OUT_CHANNEL_FIXED_PRIORITY_EN
    assign ptr = '0;
`else
    // ptr holds the index just after the last winner.
    logic [IW-1:0] ptr_next;

    always_comb begin
        ptr_next = ptr;
        for (int i = 0; i < NRequesters; i++) begin
            if (grant[i]) begin
                ptr_next = (i == NRequesters - 1) ? '0 : IW'(i + 1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) ptr <= '0;
        else        ptr <= ptr_next;
    end
`endif

endmodule

// File: tb/tb_out_channel_arbiter.sv
// Randomized self-checking bench for out_channel_arbiter.
// A queue-based reference model predicts every output each cycle.
module tb_out_channel_arbiter;
    import out_channel_pkg::*;

    localparam int W    = 12;
    localparam int N    = 4;
    localparam int NOUT = 100;

    logic           clock = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] reqData;
    logic [N-1:0]   grant;
    logic           flush;
    logic           outValid;
    logic [W-1:0]   outData;
    logic           outReady;
    logic           full;
    logic           empty;
    logic [6:0]     count;
    logic           flushDone;

    out_channel_arbiter #(
        .MemoryElementWidth(W),
        .NRequesters(N),
        .NOut(NOUT)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .reqData  (reqData),
        .grant    (grant),
        .flush    (flush),
        .outValid (outValid),
        .outData  (outData),
        .outReady (outReady),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .flushDone(flushDone)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_err = 0;
    int ngr   = 0;
    int ndone = 0;

    int q[$];
    int mst   = 0;
    int mptr  = 0;
    int mdone = 0;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int arb(input logic [N-1:0] r);
        if (mst != 0 || q.size() >= NOUT) return -1;
`ifdef OUT_CHANNEL_FIXED_PRIORITY_EN
        for (int i = 0; i < N; i++) if (r[i]) return i;
`else
        for (int k = 0; k < N; k++) begin
            int i;
            i = (mptr + k) % N;
            if (r[i]) return i;
        end
`endif
        return -1;
    endfunction

    task automatic drive(input logic [N-1:0] r,
                         input logic rdy,
                         input logic fl);
        req      = r;
        outReady = rdy;
        flush    = fl;
        for (int i = 0; i < N; i++)
            reqData[i*W +: W] = W'($urandom_range(0, 4095));
    endtask

    task automatic cyc();
        int g;
        int expg;
        #1;
        g    = arb(req);
        expg = (g < 0) ? 0 : (1 << g);
        chk("grant", 32'(grant), expg);
        chk("valid", 32'(outValid), 32'(q.size() > 0));
        if (q.size() > 0) chk("data", 32'(outData), q[0]);
        chk("count", 32'(count), q.size());
        chk("full", 32'(full), 32'(q.size() == NOUT));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("done", 32'(flushDone), mdone);
        if (grant != '0) ngr++;
        if (flushDone) ndone++;
        if (q.size() > 0 && outReady) void'(q.pop_front());
        if (g >= 0) begin
            q.push_back(int'(reqData[g*W +: W]));
            mptr = (g + 1) % N;
        end
        mdone = 0;
        if (mst == 0) begin
            if (flush) mst = 1;
        end else if (q.size() == 0) begin
            mst   = 0;
            mdone = 1;
        end
        @(negedge clock);
    endtask

    task automatic do_reset();
        req   = '1;
        flush = 1'b0;
        reset = 1'b0;
        #1;
        q.delete();
        mst   = 0;
        mptr  = 0;
        mdone = 0;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_valid", 32'(outValid), 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_done", 32'(flushDone), 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        req   = '0;
    endtask

    initial begin
        int lvl;
        reset    = 1'b1;
        req      = '0;
        reqData  = '0;
        flush    = 1'b0;
        outReady = 1'b0;
        @(negedge clock);

        // Fill to full with all requesters asking.
        do_reset();
        ngr = 0;
        repeat (NOUT) begin
            drive('1, 1'b0, 1'b0);
            cyc();
        end
        chk("fill_grants", ngr, NOUT);
        drive('1, 1'b0, 1'b0);
        #1;
        chk("fill_full", 32'(full), 1);
        chk("fill_nogrant", 32'(grant), 0);
        cyc();

        // Single write into empty buffer.
        do_reset();
        drive(4'b0001, 1'b0, 1'b0);
        reqData[W-1:0] = W'(2);
        cyc();
        drive('0, 1'b0, 1'b0);
        #1;
        chk("one_valid", 32'(outValid), 1);
        chk("one_data", 32'(outData), 2);
        chk("one_count", 32'(count), 1);
        cyc();

        // Wrap the ring positions.
        do_reset();
        repeat (99) begin
            drive('1, 1'b1, 1'b0);
            cyc();
        end
        drive('0, 1'b1, 1'b0);
        cyc();
        repeat (3) begin
            drive('1, 1'b0, 1'b0);
            cyc();
        end
        #1;
        chk("wrap_pos", 32'(dut.wr_pos), 2);
        chk("wrap_count", 32'(count), 3);
        repeat (3) begin
            drive('0, 1'b1, 1'b0);
            cyc();
        end

        // Flush with five words queued.
        do_reset();
        repeat (5) begin
            drive('1, 1'b0, 1'b0);
            cyc();
        end
        drive('0, 1'b1, 1'b1);
        cyc();
        ngr   = 0;
        ndone = 0;
        repeat (4) begin
            drive('1, 1'b1, 1'b0);
            cyc();
        end
        chk("flush_nogrant", ngr, 0);
        repeat (4) begin
            drive('1, 1'b1, 1'b0);
            cyc();
        end
        chk("flush_done_once", ndone, 1);
        chk("flush_run", 32'(dut.state), 32'(RUN));

        // Reset in the middle of a flush.
        do_reset();
        repeat (7) begin
            drive('1, 1'b0, 1'b0);
            cyc();
        end
        drive('0, 1'b0, 1'b1);
        cyc();
        repeat (2) begin
            drive('1, 1'b0, 1'b0);
            cyc();
        end
        #1;
        chk("midflush_count", 32'(count), 7);
        do_reset();
        ngr = 0;
        repeat (4) begin
            drive('1, 1'b0, 1'b0);
            cyc();
        end
        chk("resume_grants", ngr, 4);

`ifdef OUT_CHANNEL_FIXED_PRIORITY_EN
        do_reset();
        repeat (10) begin
            drive(4'b0110, 1'b1, 1'b0);
            #1;
            chk("fixed_win", 32'(grant), 32'(4'b0010));
            cyc();
        end
`endif

        // Random traffic with varying consumer rate.
        do_reset();
        lvl = 2;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) lvl = $urandom_range(0, 4);
            if ($urandom_range(0, 499) == 0) do_reset();
            drive(N'($urandom),
                  $urandom_range(0, 3) < lvl,
                  $urandom_range(0, 49) == 0);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/out_channel_arbiter.md
OUT_CHANNEL_ARBITER -- requirements
Module: out_channel_arbiter

Interface
REQ-001 SHALL have parameter MemoryElementWidth, default 12: width of each channel word.
REQ-002 SHALL have parameter NRequesters, default 4: number of writing requesters.
REQ-003 SHALL have parameter NOut, default 100: ring buffer depth in words; need not be a power of two.
REQ-004 SHALL have port clock, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port req, input, NRequesters: per-requester write request, level.
REQ-007 SHALL have port reqData, input, NRequesters*MemoryElementWidth: word i sits at bits [i*W +: W].
REQ-008 SHALL have port grant, output, NRequesters: one-hot, combinational; high means the word is accepted this edge.
REQ-009 SHALL have port flush, input, 1: a one-cycle pulse requests a drain.
REQ-010 SHALL have port outValid, output, 1: the head word is present.
REQ-011 SHALL have port outData, output, MemoryElementWidth: the head word.
REQ-012 SHALL have port outReady, input, 1: the consumer takes the head word on an edge where outValid && outReady.
REQ-013 SHALL have ports full, empty, output, 1 each; count, output, $clog2(NOut+1): occupancy.
REQ-014 SHALL have port flushDone, output, 1: one-cycle pulse when a flush completes.

Function
REQ-015 SHALL keep a ring buffer with write position outMemPos and read position readPos, each advancing as (pos+1)%NOut, wrapping from NOut-1 to 0.
REQ-016 SHALL implement states RUN and FLUSH: RUN->FLUSH on flush; FLUSH->RUN on the edge where count becomes 0 (or is already 0), pulsing flushDone with that transition.
REQ-017 SHALL issue at most one grant per cycle, only in RUN, and only when count<NOut; grant ignores a pop in the same cycle (no full-bypass).
REQ-018 SHALL select among asserted req by round-robin: search starts at the index after the last granted requester, which is recorded on each grant.
REQ-019 SHALL write the granted word at outMemPos on the edge; it becomes visible on outData/outValid the next cycle if the buffer was empty (1-cycle latency).
REQ-020 SHALL drive outValid = !empty and outData = mem[readPos]; a pop advances readPos.
REQ-021 SHALL handle simultaneous push and pop with count unchanged and both positions advancing.
REQ-022 SHALL continue pops during FLUSH and hold all grants low; a flush pulse during FLUSH is ignored.
REQ-023 SHALL drive full = (count==NOut) and empty = (count==0), both derived from registered count.

Reset
REQ-024 SHALL, on reset low, immediately clear outMemPos, readPos, count and the round-robin pointer to 0, set state to RUN, and drive flushDone=0; this holds mid-flush and mid-transfer.
REQ-025 SHALL, while in reset, drive grant=0, outValid=0, empty=1, full=0; buffer contents are don't-care.

Configuration
REQ-026 SHALL support OUT_CHANNEL_FIXED_PRIORITY_EN: when defined, arbitration is fixed priority with the lowest index winning and no round-robin pointer; when undefined, the round-robin scheme of REQ-018 applies.

Structure
REQ-027 SHALL take the state enum {RUN, FLUSH} and default widths/depths from a shared package, out_channel_pkg.
REQ-028 SHALL place arbitration in one sub-module, out_channel_rr_arbiter (req, last grant -> one-hot grant); the ring buffer stays in the top module.

Verification
REQ-029 The bench SHALL cover: req=4'b1111 held, outReady=0, NOut=100 -> grants in order 0,1,2,3,0,… and 100 grants total; then full=1 and grant=0.
REQ-030 The bench SHALL cover: a single write of 2 from requester 0 into an empty buffer -> outValid=1 with outData=2 on the next cycle, and count=1.
REQ-031 The bench SHALL cover: 99 push+pop cycles followed by 3 pushes -> outMemPos wraps to 2, data order is preserved, and count=3.
REQ-032 The bench SHALL cover: count=5, flush pulse, outReady=1 -> no grants for 5 cycles, flushDone pulses once, then state is RUN.
REQ-033 The bench SHALL cover: reset asserted mid-flush with count=7 -> count=0, empty=1 and flushDone=0 immediately; normal grants resume after release.
REQ-034 The bench SHALL cover: with OUT_CHANNEL_FIXED_PRIORITY_EN defined and req=4'b0110 held -> requester 1 wins every cycle.
